read_request_port: RTL and testbench

Core-side read master sitting directly upstream of the daisy-chained read arbiter. It accepts a byte or 16-bit word read command from a PLC core and raises the arbiter request. It holds the address stable through the grant, captures the RAM byte on each acknowledge, and masks the arbiter's one-cycle-late stale acknowledge. It then returns the assembled result to the core with a one-cycle done pulse.

---
 rtl/read_request_port.sv | 169 ++++++++++++++++
 tb/tb_read_request_port.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/read_request_port.sv
// Core-side read master for the daisy-chained read arbiter: byte/word reads with stale-ACK masking.
// Optional per-byte request timeout enabled by defining READPORT_TIMEOUT_EN.
module read_request_port #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        READPORT_CORE_START,
  input  logic [15:0] READPORT_CORE_ADDR,
  input  logic        READPORT_CORE_WORD,
  output logic        READPORT_CORE_BUSY,
  output logic        READPORT_CORE_DONE,
  output logic [15:0] READPORT_CORE_DATA,
  output logic        READPORT_CORE_ERROR,
  output logic        READPORT_READ_REQUEST,
  output logic [15:0] READPORT_ARB_ADDR,
  input  logic [7:0]  READPORT_ARB_DATA,
  input  logic        READPORT_ARB_ACK
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        word_q, word_d;
  logic        idx_q, idx_d;
  logic [7:0]  byte0_q, byte0_d;
  logic [7:0]  byte1_q, byte1_d;
  logic        drain_q, drain_d;
  logic        err_q, err_d;
  logic        req_q, req_d;
  logic [15:0] arb_addr_q, arb_addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] data_q, data_d;
  logic        error_q, error_d;
`ifdef READPORT_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  tmo_q, tmo_d;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_d     = word_q;
    idx_d      = idx_q;
    byte0_d    = byte0_q;
    byte1_d    = byte1_q;
    drain_d    = drain_q;
    err_d      = err_q;
    req_d      = req_q;
    arb_addr_d = arb_addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    data_d     = data_q;
    error_d    = error_q;
`ifdef READPORT_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (READPORT_CORE_START) begin
          addr_d     = READPORT_CORE_ADDR;
          word_d     = READPORT_CORE_WORD;
          idx_d      = 1'b0;
          err_d      = 1'b0;
          req_d      = 1'b1;
          arb_addr_d = READPORT_CORE_ADDR;
          busy_d     = 1'b1;
          state_d    = S_REQ;
`ifdef READPORT_TIMEOUT_EN
          tmo_d      = 8'd0;
`endif
        end
      end
      S_REQ: begin
        // ACK beats a coincident timeout expiry
        if (READPORT_ARB_ACK) begin
          if (idx_q) byte1_d = READPORT_ARB_DATA;
          else       byte0_d = READPORT_ARB_DATA;
          req_d   = 1'b0;
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end
`ifdef READPORT_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      S_DRAIN: begin
        // two dead cycles swallow the stale ACK the arbiter emits after a drop
        if (!drain_q) begin
          drain_d = 1'b1;
        end else if (word_q && !idx_q && !err_q) begin
          idx_d      = 1'b1;
          arb_addr_d = addr_q + 16'd1;
          req_d      = 1'b1;
          state_d    = S_REQ;
`ifdef READPORT_TIMEOUT_EN
          tmo_d      = 8'd0;
`endif
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          error_d = err_q;
          if (err_q)       data_d = 16'h0000;
          else if (word_q) data_d = {byte1_q, byte0_q};
          else             data_d = {8'h00, byte0_q};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      addr_q     <= 16'h0000;
      word_q     <= 1'b0;
      idx_q      <= 1'b0;
      byte0_q    <= 8'h00;
      byte1_q    <= 8'h00;
      drain_q    <= 1'b0;
      err_q      <= 1'b0;
      req_q      <= 1'b0;
      arb_addr_q <= 16'h0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= 16'h0000;
      error_q    <= 1'b0;
`ifdef READPORT_TIMEOUT_EN
      tmo_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      byte0_q    <= byte0_d;
      byte1_q    <= byte1_d;
      drain_q    <= drain_d;
      err_q      <= err_d;
      req_q      <= req_d;
      arb_addr_q <= arb_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      data_q     <= data_d;
      error_q    <= error_d;
`ifdef READPORT_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign READPORT_CORE_BUSY    = busy_q;
  assign READPORT_CORE_DONE    = done_q;
  assign READPORT_CORE_DATA    = data_q;
  assign READPORT_CORE_ERROR   = error_q;
  assign READPORT_READ_REQUEST = req_q;
  assign READPORT_ARB_ADDR     = arb_addr_q;

endmodule

// File: tb/tb_read_request_port.sv
// Scoreboard bench for read_request_port with a small registered-arbiter model.
module tb_read_request_port;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [15:0] ADDR = 16'h0;
  logic        WORD = 1'b0;
  logic        BUSY, DONE, ERROR, REQUEST;
  logic [15:0] DATA, ARB_ADDR;
  logic [7:0]  ARB_DATA = 8'h00;
  logic        ARB_ACK = 1'b0;

`ifdef READPORT_TIMEOUT_EN
  localparam int unsigned TMO = 4;
`else
  localparam int unsigned TMO = 255;
`endif

  read_request_port #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .READPORT_CORE_START(START), .READPORT_CORE_ADDR(ADDR), .READPORT_CORE_WORD(WORD),
    .READPORT_CORE_BUSY(BUSY), .READPORT_CORE_DONE(DONE), .READPORT_CORE_DATA(DATA),
    .READPORT_CORE_ERROR(ERROR), .READPORT_READ_REQUEST(REQUEST), .READPORT_ARB_ADDR(ARB_ADDR),
    .READPORT_ARB_DATA(ARB_DATA), .READPORT_ARB_ACK(ARB_ACK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          done_cyc;  // -1: latency not checked
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          last_ack = 0;
  logic [15:0] exp_a = 16'h0;
  logic        carry = 1'b1;
  logic        stale_en = 1'b0;
  logic        req_r = 1'b0;
  logic [7:0]  ram [0:65535];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Arbiter model: request register then ACK register; optional one stale ACK cycle carrying junk data.
  always @(posedge CLK) begin
    req_r   <= REQUEST & carry & ~ARB_ACK;
    ARB_ACK <= req_r & (stale_en | ~ARB_ACK);
    ARB_DATA <= (req_r && ARB_ACK) ? 8'hEE : ram[ARB_ADDR];
  end

  // Monitor: address stability while requesting and scoreboard pop on DONE.
  always @(negedge CLK) begin
    if (!RST && REQUEST) begin
      chk("arb_addr", {16'h0, ARB_ADDR}, {16'h0, exp_a});
      if (ARB_ACK) begin
        last_ack = cyc;
        exp_a = exp_a + 16'd1;
      end
    end
    if (DONE) begin
      if (sb.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_done: got DONE at cyc %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data", {16'h0, DATA}, {16'h0, e.data});
        chk("error", {31'h0, ERROR}, {31'h0, e.err});
        chk("busy_at_done", {31'h0, BUSY}, 32'h0);
        if (e.done_cyc >= 0) chk("done_cycle", cyc, e.done_cyc);
        if (!e.err) chk("ack_to_done", cyc - last_ack, 3);
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge CLK);
    if (sb.size() != 0) begin
      errors++; checks++;
      $display("FAIL done_timeout: got no DONE expected DONE");
      sb.delete();
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic w, input logic [15:0] d,
                       input logic e, input int lat);
    @(negedge CLK);
    START = 1'b1; ADDR = a; WORD = w; exp_a = a;
    sb.push_back('{data: d, err: e, done_cyc: (lat < 0) ? -1 : cyc + lat});
    @(negedge CLK);
    START = 1'b0;
    chk("busy_after_start", {31'h0, BUSY}, 32'h1);
    chk("req_after_start", {31'h0, REQUEST}, 32'h1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'(i) ^ 8'h5C;
    ram[16'h1234] = 8'hA5;
    ram[16'hFFFF] = 8'h11;
    ram[16'h0000] = 8'h22;
    ram[16'h0300] = 8'h5A;
    ram[16'h0301] = 8'hC3;
    ram[16'h0400] = 8'h77;
    ram[16'h0200] = 8'h3C;
    repeat (3) @(negedge CLK);
    chk("rst_req", {31'h0, REQUEST}, 32'h0);
    chk("rst_addr", {16'h0, ARB_ADDR}, 32'h0);
    chk("rst_busy", {31'h0, BUSY}, 32'h0);
    chk("rst_done", {31'h0, DONE}, 32'h0);
    chk("rst_data", {16'h0, DATA}, 32'h0);
    chk("rst_error", {31'h0, ERROR}, 32'h0);
    RST = 1'b0;

    issue(16'h1234, 1'b0, 16'h00A5, 1'b0, 6);
    wait_done();
    issue(16'hFFFF, 1'b1, 16'h2211, 1'b0, 11);
    wait_done();

    stale_en = 1'b1;
    issue(16'h0300, 1'b1, 16'hC35A, 1'b0, 11);
    wait_done();
    stale_en = 1'b0;

`ifndef READPORT_TIMEOUT_EN
    carry = 1'b0;
    issue(16'h0400, 1'b0, 16'h0077, 1'b0, -1);
    repeat (3) @(negedge CLK);
    START = 1'b1; ADDR = 16'h9999; WORD = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (14) @(negedge CLK);
    carry = 1'b1;
    wait_done();
`endif

    carry = 1'b0;
    issue(16'h0100, 1'b1, 16'h0000, 1'b0, -1);
    @(negedge CLK);
    RST = 1'b1;
    sb.delete();
    @(negedge CLK);
    chk("midrst_req", {31'h0, REQUEST}, 32'h0);
    chk("midrst_busy", {31'h0, BUSY}, 32'h0);
    chk("midrst_data", {16'h0, DATA}, 32'h0);
    chk("midrst_done", {31'h0, DONE}, 32'h0);
    RST = 1'b0;
    carry = 1'b1;
    repeat (3) @(negedge CLK);
    issue(16'h0200, 1'b0, 16'h003C, 1'b0, 6);
    wait_done();

`ifdef READPORT_TIMEOUT_EN
    carry = 1'b0;
    issue(16'h0500, 1'b1, 16'h0000, 1'b1, 7);
    wait_done();
    carry = 1'b1;
`endif

    repeat (5) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
